order_queue: RTL
================

# order_queue

Parametrised single-clock order queue that buffers packed accelerator orders between the order decoder and the layer scheduler. It replaces the fixed two-clock order cache wherever producer and consumer share `system_clk`. It generalises width and depth and adds:
- first-word-fall-through valid/ready output
- occupancy count and peak watermark
- synchronous flush
- sticky overflow/underflow error flags

## Interface
- `ORDER_W`, 256, packed order word width (field layout in `order_pkg`; ≥ `ORDER_PAYLOAD_W`).
- `DEPTH`, 16, capacity in orders; power of two, ≥ 4.
- `AFULL_MARGIN`, 2, free slots reserved after `order_in_ready` drops; 1 ≤ value < `DEPTH`.
- `system_clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous discard of all held orders.
- `push_order_en`  in  1  write request.
- `order_in`  in  `ORDER_W`  order word to write.
- `order_in_ready`  out  1  almost-full complement; advisory.
- `order_valid`  out  1  `order_out` holds the oldest order.
- `order_out`  out  `ORDER_W`  oldest order, registered.
- `pop_order_en`  in  1  consumer ready; pop when `order_valid`.
- `order_count`  out  `$clog2(DEPTH)+1`  orders held.
- `max_count`  out  `$clog2(DEPTH)+1`  peak `order_count` since reset or `err_clear`.
- `overflow`  out  1  sticky: push dropped while full.
- `underflow`  out  1  sticky: pop while `order_valid`=0.
- `err_clear`  in  1  clears `overflow`, `underflow` and `max_count`.

## Operation
- Reset values:
  - `order_count`, `max_count`, `order_out`: 0
  - `order_valid`, `overflow`, `underflow`: 0
  - `order_in_ready`: 1
  - storage contents: don't-care
- Push accepted ⇔ `push_order_en` & `order_count` < `DEPTH` & !`flush`. `order_in_ready` is ignored for acceptance.
- Pop occurs ⇔ `pop_order_en` & `order_valid` & !`flush`.
- Count update:
  - +1 on accepted push only
  - −1 on pop only
  - unchanged when both occur
  - 0 on `flush`
- Full rule: a push with `order_count`==`DEPTH` is dropped and sets `overflow`. This holds even when a pop occurs in the same cycle.
- `pop_order_en` with `order_valid`=0 sets `underflow`. It has no other effect, including when it coincides with a push into an empty queue.
- `order_in_ready` = (`order_count` < `DEPTH`−`AFULL_MARGIN`). It is registered, i.e. a function of the registered count.
- `order_valid` = (`order_count` ≠ 0). `order_out` always equals the oldest held order when valid and holds its last value when invalid.
- Ordering is strict FIFO; a word is never duplicated or reordered. Pointers wrap modulo `DEPTH`.
- `flush` has priority over push and pop. Sticky flags and `max_count` are unaffected by `flush`.
- `max_count` <= max(`max_count`, next `order_count`).
- `err_clear`: flags and `max_count` are cleared. Set has priority when a new error occurs in the same cycle, and `max_count` loads the next count.

## Timing
- Push→visible latency is 1 cycle. A word accepted at edge k into an empty queue gives `order_valid`=1 with that `order_out` after edge k.
- After a pop at edge k, the next order is on `order_out` immediately after edge k. Back-to-back pops sustain 1 order/cycle.
- `order_count`, `order_in_ready`, flags and `max_count` all update on the same edge as the causing event.
- Reset is asynchronous assert. Deassertion is synchronised externally; the block samples inputs from the first edge after `rst` falls.

## Structure
- `order_pkg` holds:
  - `ORDER_PAYLOAD_W`=233
  - field LSB/width constants: order[2:0], input_base_addr[34:3], input_patch_num[42:35], output_patch_num[50:43], double_patch[51], patch_num[83:52], row_size[93:84], col_size[103:94], weight_quant[107:104], fea_in_quant[111:108], fea_out_quant[115:112], stride[116], padding[119:117], return_patch_num[135:120], return_addr[167:136], weight_data_length[199:168], activate[200], id[232:201]
  - upper bits zero
- One sub-module, `order_queue_mem`: a `DEPTH`×`ORDER_W` simple dual-port RAM with a registered read. Control logic (pointers, count, FWFT output register, flags) stays in `order_queue`.

## Test plan
All scenarios use `DEPTH`=16, `AFULL_MARGIN`=2.
- Reset mid-traffic (count 7) → all outputs return to reset values asynchronously. First push after release is visible 1 cycle later.
- Push 17 words 0x1..0x11 back-to-back, no pops:
  - `order_in_ready` falls after 14th accept
  - `order_count`=16
  - 17th dropped, `overflow`=1, `max_count`=16
  - 16 pops return 0x1..0x10 in order
- Hold `order_count`=5; push and pop every cycle for 40 cycles → count stays 5; output sequence equals input sequence delayed by 5.
- Queue empty; push 0xA5 and pop same cycle → `underflow`=1, count 1. Next cycle `order_out`=0xA5, `order_valid`=1.
- Count 9; `flush` with push and pop asserted → count 0, `order_valid`=0, pushed word absent; `max_count` stays 9.
- Count 16; `err_clear` with a push in the same cycle → `overflow` remains 1, `max_count`=16. `err_clear` alone next cycle → both cleared.

Source files
------------

// File: rtl/order_pkg.sv
// Packed accelerator order layout shared by the order decoder, the order queue
// and the layer scheduler.
package order_pkg;

  localparam int unsigned ORDER_WORD_W    = 256;
  localparam int unsigned ORDER_PAYLOAD_W = 233;

  localparam int unsigned ORD_OP_LSB             = 0;
  localparam int unsigned ORD_OP_W               = 3;
  localparam int unsigned ORD_IN_BASE_ADDR_LSB   = 3;
  localparam int unsigned ORD_IN_BASE_ADDR_W     = 32;
  localparam int unsigned ORD_IN_PATCH_NUM_LSB   = 35;
  localparam int unsigned ORD_IN_PATCH_NUM_W     = 8;
  localparam int unsigned ORD_OUT_PATCH_NUM_LSB  = 43;
  localparam int unsigned ORD_OUT_PATCH_NUM_W    = 8;
  localparam int unsigned ORD_DOUBLE_PATCH_LSB   = 51;
  localparam int unsigned ORD_DOUBLE_PATCH_W     = 1;
  localparam int unsigned ORD_PATCH_NUM_LSB      = 52;
  localparam int unsigned ORD_PATCH_NUM_W        = 32;
  localparam int unsigned ORD_ROW_SIZE_LSB       = 84;
  localparam int unsigned ORD_ROW_SIZE_W         = 10;
  localparam int unsigned ORD_COL_SIZE_LSB       = 94;
  localparam int unsigned ORD_COL_SIZE_W         = 10;
  localparam int unsigned ORD_WEIGHT_QUANT_LSB   = 104;
  localparam int unsigned ORD_WEIGHT_QUANT_W     = 4;
  localparam int unsigned ORD_FEA_IN_QUANT_LSB   = 108;
  localparam int unsigned ORD_FEA_IN_QUANT_W     = 4;
  localparam int unsigned ORD_FEA_OUT_QUANT_LSB  = 112;
  localparam int unsigned ORD_FEA_OUT_QUANT_W    = 4;
  localparam int unsigned ORD_STRIDE_LSB         = 116;
  localparam int unsigned ORD_STRIDE_W           = 1;
  localparam int unsigned ORD_PADDING_LSB        = 117;
  localparam int unsigned ORD_PADDING_W          = 3;
  localparam int unsigned ORD_RET_PATCH_NUM_LSB  = 120;
  localparam int unsigned ORD_RET_PATCH_NUM_W    = 16;
  localparam int unsigned ORD_RET_ADDR_LSB       = 136;
  localparam int unsigned ORD_RET_ADDR_W         = 32;
  localparam int unsigned ORD_WEIGHT_LEN_LSB     = 168;
  localparam int unsigned ORD_WEIGHT_LEN_W       = 32;
  localparam int unsigned ORD_ACTIVATE_LSB       = 200;
  localparam int unsigned ORD_ACTIVATE_W         = 1;
  localparam int unsigned ORD_ID_LSB             = 201;
  localparam int unsigned ORD_ID_W               = 32;

  // Declared MSB first so the packed struct matches the bit positions above.
  typedef struct packed {
    logic [31:0] id;
    logic        activate;
    logic [31:0] weight_data_length;
    logic [31:0] return_addr;
    logic [15:0] return_patch_num;
    logic [2:0]  padding;
    logic        stride;
    logic [3:0]  fea_out_quant;
    logic [3:0]  fea_in_quant;
    logic [3:0]  weight_quant;
    logic [9:0]  col_size;
    logic [9:0]  row_size;
    logic [31:0] patch_num;
    logic        double_patch;
    logic [7:0]  output_patch_num;
    logic [7:0]  input_patch_num;
    logic [31:0] input_base_addr;
    logic [2:0]  order;
  } order_fields_t;

  // Upper bits of the order word above the payload are always zero.
  function automatic logic [ORDER_WORD_W-1:0] pack_order(input order_fields_t f);
    logic [ORDER_WORD_W-1:0] w;
    w = '0;
    w[ORDER_PAYLOAD_W-1:0] = f;
    return w;
  endfunction

  function automatic order_fields_t unpack_order(input logic [ORDER_WORD_W-1:0] w);
    return order_fields_t'(w[ORDER_PAYLOAD_W-1:0]);
  endfunction

endpackage

// File: rtl/order_queue_mem.sv
// DEPTH x WIDTH simple dual-port storage for order_queue; one write port and
// one read port whose data is registered and only updates when rd_en is high.
module order_queue_mem
  import order_pkg::*;
#(
  parameter int unsigned WIDTH = ORDER_WORD_W,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     system_clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge system_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/order_queue.sv
// Single-clock first-word-fall-through order queue between the order decoder
// and the layer scheduler, with occupancy, peak watermark, flush and error flags.
module order_queue
  import order_pkg::*;
#(
  parameter int unsigned ORDER_W      = ORDER_WORD_W,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input  logic                       system_clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push_order_en,
  input  logic [ORDER_W-1:0]         order_in,
  output logic                       order_in_ready,
  output logic                       order_valid,
  output logic [ORDER_W-1:0]         order_out,
  input  logic                       pop_order_en,
  output logic [$clog2(DEPTH):0]     order_count,
  output logic [$clog2(DEPTH):0]     max_count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clear
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] READY_LIM = CW'(DEPTH - AFULL_MARGIN);

  logic [CW-1:0]      count_q;
  logic [CW-1:0]      count_nxt;
  logic [CW-1:0]      max_q;
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [AW-1:0]      head_addr;
  logic               full;
  logic               push_do;
  logic               pop_do;
  logic               load_head;
  logic               bypass_sel;
  logic               ram_rd_en;
  logic [ORDER_W-1:0] ram_rd_data;
  logic [ORDER_W-1:0] bypass_q;
  logic               sel_bypass_q;
  logic               ovf_q;
  logic               unf_q;

  assign full        = (count_q == DEPTH_C);
  assign order_valid = (count_q != '0);

  always_comb begin
    push_do   = push_order_en & ~full & ~flush;
    pop_do    = pop_order_en & order_valid & ~flush;
    count_nxt = count_q;
    if (flush) begin
      count_nxt = '0;
    end else if (push_do && !pop_do) begin
      count_nxt = count_q + CW'(1);
    end else if (pop_do && !push_do) begin
      count_nxt = count_q - CW'(1);
    end
    // Slot that will be the oldest order after this edge.
    head_addr  = order_valid ? rd_ptr_q + AW'(1) : rd_ptr_q;
    load_head  = (count_nxt != '0) & (order_valid ? pop_do : push_do);
    // The new head is being written this very cycle, so the RAM cannot
    // return it yet; take it straight from order_in instead.
    bypass_sel = load_head & push_do & (head_addr == wr_ptr_q);
    ram_rd_en  = load_head & ~bypass_sel;
  end

  order_queue_mem #(
    .WIDTH (ORDER_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .system_clk (system_clk),
    .wr_en      (push_do),
    .wr_addr    (wr_ptr_q),
    .wr_data    (order_in),
    .rd_en      (ram_rd_en),
    .rd_addr    (head_addr),
    .rd_data    (ram_rd_data)
  );

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      max_q        <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      sel_bypass_q <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_do) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop_do)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_nxt;
      if (err_clear || (count_nxt > max_q)) begin
        max_q <= count_nxt;
      end
      // A new error in the same cycle as err_clear wins.
      ovf_q <= (push_order_en & full) | (ovf_q & ~err_clear);
      unf_q <= (pop_order_en & ~order_valid) | (unf_q & ~err_clear);
      if (load_head) begin
        sel_bypass_q <= bypass_sel;
      end
    end
  end

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      bypass_q <= '0;
    end else if (bypass_sel) begin
      bypass_q <= order_in;
    end
  end

  assign order_out      = sel_bypass_q ? bypass_q : ram_rd_data;
  assign order_in_ready = (count_q < READY_LIM);
  assign order_count    = count_q;
  assign max_count      = max_q;
  assign overflow       = ovf_q;
  assign underflow      = unf_q;

endmodule
